immgen_stage: RTL and testbench

//   Registered immediate-generation stage for the R4 decode path. Accepts one instruction

---
 rtl/immgen_stage_if.sv | 26 ++
 rtl/immgen_stage.sv | 130 +++++++++++++
 tb/tb_immgen_stage.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/immgen_stage_if.sv
// rtl/immgen_stage_if.sv - instruction in / decoded immediate out handshake bundle
interface immgen_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/immgen_stage.sv
// rtl/immgen_stage.sv - registered RV32I immediate generator with 2-entry skid buffer
module immgen_stage #(
  parameter int XLEN      = 32,
  parameter bit ILLEGAL_Z = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  immgen_stage_if.slave bus
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t state;

  logic [31:0]        ins;
  logic [6:0]         opc;
  logic signed [31:0] imm_i;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]    dec_imm;
  logic [2:0]         dec_fmt;
  logic               dec_ill;
  logic               accept;

  logic [31:0]     m_instr, k_instr;
  logic [XLEN-1:0] m_pc, k_pc;
  logic [XLEN-1:0] m_imm, k_imm;
  logic [2:0]      m_fmt, k_fmt;
  logic            m_ill, k_ill;

  assign ins   = bus.in_instr;
  assign opc   = ins[6:0];
  assign imm_i = {{20{ins[31]}}, ins[31:20]};

  always_comb begin
    dec_fmt = FMT_ILL;
    dec_ill = 1'b1;
    imm32   = ILLEGAL_Z ? 32'sd0 : imm_i;
    case (opc)
      7'b0110011: begin
        dec_fmt = FMT_R; dec_ill = 1'b0; imm32 = 32'sd0;
      end
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
        dec_fmt = FMT_I; dec_ill = 1'b0; imm32 = imm_i;
      end
      7'b0100011: begin
        dec_fmt = FMT_S; dec_ill = 1'b0;
        imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'b1100011: begin
        dec_fmt = FMT_B; dec_ill = 1'b0;
        imm32 = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U; dec_ill = 1'b0;
        imm32 = {ins[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt = FMT_J; dec_ill = 1'b0;
        imm32 = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  // Signed cast widens from bit 31, which also gives the U-type extension at XLEN=64.
  assign dec_imm = XLEN'(imm32);

  assign bus.in_ready    = (state != FULL) && !reset;
  assign accept          = bus.in_valid && bus.in_ready;
  assign bus.out_valid   = state[1];
  assign bus.out_instr   = m_instr;
  assign bus.out_pc      = m_pc;
  assign bus.out_imm     = m_imm;
  assign bus.out_fmt     = m_fmt;
  assign bus.out_illegal = m_ill;

  // Data registers only load on an accept or a skid drain, never on idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      m_instr <= '0; m_pc <= '0; m_imm <= '0; m_fmt <= '0; m_ill <= 1'b0;
      k_instr <= '0; k_pc <= '0; k_imm <= '0; k_fmt <= '0; k_ill <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            m_instr <= ins; m_pc <= bus.in_pc; m_imm <= dec_imm;
            m_fmt <= dec_fmt; m_ill <= dec_ill;
            state <= ONE;
          end
        end
        ONE: begin
          if (bus.out_ready) begin
            if (accept) begin
              m_instr <= ins; m_pc <= bus.in_pc; m_imm <= dec_imm;
              m_fmt <= dec_fmt; m_ill <= dec_ill;
            end else begin
              state <= EMPTY;
            end
          end else if (accept) begin
            k_instr <= ins; k_pc <= bus.in_pc; k_imm <= dec_imm;
            k_fmt <= dec_fmt; k_ill <= dec_ill;
            state <= FULL;
          end
        end
        FULL: begin
          if (bus.out_ready) begin
            m_instr <= k_instr; m_pc <= k_pc; m_imm <= k_imm;
            m_fmt <= k_fmt; m_ill <= k_ill;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_immgen_stage.sv
// tb/tb_immgen_stage.sv - directed self-checking bench for immgen_stage
module tb_immgen_stage;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fails = 0;

  always #5 clk = ~clk;

  immgen_stage_if #(.XLEN(32)) b32 ();
  immgen_stage_if #(.XLEN(64)) b64 ();

  immgen_stage #(.XLEN(32), .ILLEGAL_Z(1'b1)) dut32 (.clk(clk), .reset(reset), .bus(b32.slave));
  immgen_stage #(.XLEN(64), .ILLEGAL_Z(1'b1)) dut64 (.clk(clk), .reset(reset), .bus(b64.slave));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    b32.in_valid = 1'b1;
    b32.in_instr = instr;
    b32.in_pc    = pc;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                            input logic [31:0] imm, input logic [2:0] fmt, input logic ill);
    check({tag, ".valid"}, 64'(b32.out_valid), 64'd1);
    check({tag, ".instr"}, 64'(b32.out_instr), 64'(instr));
    check({tag, ".pc"}, 64'(b32.out_pc), 64'(pc));
    check({tag, ".imm"}, 64'(b32.out_imm), 64'(imm));
    check({tag, ".fmt"}, 64'(b32.out_fmt), 64'(fmt));
    check({tag, ".ill"}, 64'(b32.out_illegal), 64'(ill));
  endtask

  initial begin
    b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_pc = '0; b32.out_ready = 1'b1;
    b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_pc = '0; b64.out_ready = 1'b1;

    step();
    step();
    check("rst.in_ready", 64'(b32.in_ready), 64'd0);
    check("rst.out_valid", 64'(b32.out_valid), 64'd0);
    check("rst.imm", 64'(b32.out_imm), 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst.in_ready", 64'(b32.in_ready), 64'd1);

    // lw x0,-1(x0) alongside lui x1,0x80000 on the 64-bit instance
    send(32'hFFF0_2003, 32'h0000_0100);
    b64.in_valid = 1'b1; b64.in_instr = 32'h8000_00B7; b64.in_pc = 64'h0000_0001_0000_0000;
    step();
    expect_out("lw", 32'hFFF0_2003, 32'h100, 32'hFFFF_FFFF, 3'd1, 1'b0);
    check("lui64.valid", 64'(b64.out_valid), 64'd1);
    check("lui64.fmt", 64'(b64.out_fmt), 64'd4);
    check("lui64.imm", b64.out_imm, 64'hFFFF_FFFF_8000_0000);
    check("lui64.pc", b64.out_pc, 64'h0000_0001_0000_0000);
    b64.in_valid = 1'b0;

    // sw then beq back-to-back
    send(32'hFE00_2F23, 32'h104);
    step();
    expect_out("sw", 32'hFE00_2F23, 32'h104, 32'hFFFF_FFFE, 3'd2, 1'b0);
    send(32'hE000_0FE3, 32'h108);
    step();
    expect_out("beq", 32'hE000_0FE3, 32'h108, 32'hFFFF_FE1E, 3'd3, 1'b0);
    send(32'hFFFF_F06F, 32'h10C);
    step();
    expect_out("jal", 32'hFFFF_F06F, 32'h10C, 32'hFFFF_FFFE, 3'd5, 1'b0);
    send(32'h1234_5017, 32'h110);
    step();
    expect_out("auipc", 32'h1234_5017, 32'h110, 32'h1234_5000, 3'd4, 1'b0);
    send(32'h0000_007F, 32'h114);
    step();
    expect_out("illegal", 32'h0000_007F, 32'h114, 32'h0, 3'd7, 1'b1);
    send(32'hFFF0_0033, 32'h118);
    step();
    expect_out("add", 32'hFFF0_0033, 32'h118, 32'h0, 3'd0, 1'b0);
    b32.in_valid = 1'b0;
    step();
    check("drain.out_valid", 64'(b32.out_valid), 64'd0);

    // Back-pressure: A, B, C with consumer stalled
    b32.out_ready = 1'b0;
    send(32'h0010_0093, 32'h200);
    step();
    expect_out("bp.A0", 32'h0010_0093, 32'h200, 32'h1, 3'd1, 1'b0);
    check("bp.ready_A", 64'(b32.in_ready), 64'd1);
    send(32'hFE00_2F23, 32'h204);
    step();
    expect_out("bp.A1", 32'h0010_0093, 32'h200, 32'h1, 3'd1, 1'b0);
    check("bp.ready_B", 64'(b32.in_ready), 64'd0);
    send(32'hFFFF_F06F, 32'h208);
    step();
    step();
    expect_out("bp.A2", 32'h0010_0093, 32'h200, 32'h1, 3'd1, 1'b0);
    check("bp.ready_C", 64'(b32.in_ready), 64'd0);
    b32.out_ready = 1'b1;
    step();
    expect_out("bp.B", 32'hFE00_2F23, 32'h204, 32'hFFFF_FFFE, 3'd2, 1'b0);
    check("bp.ready_one", 64'(b32.in_ready), 64'd1);
    step();
    expect_out("bp.C", 32'hFFFF_F06F, 32'h208, 32'hFFFF_FFFE, 3'd5, 1'b0);
    b32.in_valid = 1'b0;
    step();
    check("bp.no_dup", 64'(b32.out_valid), 64'd0);

    // Fill to FULL, then reset with an input presented
    b32.out_ready = 1'b0;
    send(32'h0010_0093, 32'h300);
    step();
    send(32'h0020_0093, 32'h304);
    step();
    check("full.in_ready", 64'(b32.in_ready), 64'd0);
    reset = 1'b1;
    send(32'h0030_0093, 32'h308);
    b32.in_valid = 1'b1;
    step();
    check("rstf.out_valid", 64'(b32.out_valid), 64'd0);
    check("rstf.in_ready", 64'(b32.in_ready), 64'd0);
    check("rstf.imm", 64'(b32.out_imm), 64'd0);
    check("rstf.pc", 64'(b32.out_pc), 64'd0);
    check("rstf.instr", 64'(b32.out_instr), 64'd0);
    check("rstf.fmt", 64'(b32.out_fmt), 64'd0);
    check("rstf.ill", 64'(b32.out_illegal), 64'd0);
    reset = 1'b0;
    b32.in_valid = 1'b0;
    #1;
    check("rstf.rel_ready", 64'(b32.in_ready), 64'd1);
    step();
    check("rstf.not_taken", 64'(b32.out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
